// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 16-step unsigned shift-add multiply / restoring divide that stalls the pipeline while busy.
// Define MULDIV_EARLY_OUT_EN to end a multiply as soon as the remaining multiplier is zero.
module muldiv_sequencer #(
    parameter int REG_DATA_WIDTH = 16,
    parameter int ALU_CONTROL_WIDTH = 4,
    parameter logic [ALU_CONTROL_WIDTH-1:0] MUL_CODE = 4'b1000,
    parameter logic [ALU_CONTROL_WIDTH-1:0] DIV_CODE = 4'b1001,
    parameter int CNT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ALU_CONTROL_WIDTH-1:0] alu_control,
    input  logic [REG_DATA_WIDTH-1:0]    a,
    input  logic [REG_DATA_WIDTH-1:0]    b,
    input  logic                         flush,
    output logic                         stall,
    output logic                         busy,
    output logic                         done,
    output logic [REG_DATA_WIDTH-1:0]    r,
    output logic [REG_DATA_WIDTH-1:0]    s,
    output logic                         exc_div
);
    localparam int W = REG_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               r_state, w_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2*W-1:0]       r_acc, r_mc, w_mul_acc;
    logic [W-1:0]         r_mp, r_r, r_s, w_quo, w_rem;
    logic [W:0]           w_shift, w_diff;
    logic                 r_exc, w_is_mul, w_is_div, w_last, w_mul_last, w_fits;

    assign w_is_mul  = start && alu_control == MUL_CODE;
    assign w_is_div  = start && alu_control == DIV_CODE;
    assign w_last    = r_cnt == CNT_WIDTH'(W - 1);
    assign w_mul_acc = r_acc + (r_mp[0] ? r_mc : '0);
    // Divide keeps {remainder, dividend/quotient} in r_acc; r_mp holds the divisor.
    assign w_shift   = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_diff    = w_shift - {1'b0, r_mp};
    assign w_fits    = !w_diff[W];
    assign w_rem     = w_fits ? w_diff[W-1:0] : w_shift[W-1:0];
    assign w_quo     = {r_acc[W-2:0], w_fits};
`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_last = w_last || (r_mp >> 1) == '0;
`else
    assign w_mul_last = w_last;
`endif

    always_comb begin
        w_next = r_state;
        if (flush)
            w_next = IDLE;
        else
            case (r_state)
                IDLE:    w_next = w_is_mul ? MUL : w_is_div ? (b == '0 ? DONE : DIV) : IDLE;
                MUL:     w_next = w_mul_last ? DONE : MUL;
                DIV:     w_next = w_last ? DONE : DIV;
                default: w_next = IDLE;
            endcase
    end

    assign stall   = (r_state == IDLE && !flush && (w_is_mul || w_is_div)) || r_state == MUL || r_state == DIV;
    assign busy    = r_state != IDLE;
    assign done    = r_state == DONE && !flush;
    assign exc_div = done && r_exc;
    assign r       = r_r;
    assign s       = r_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mc    <= '0;
            r_mp    <= '0;
            r_r     <= '0;
            r_s     <= '0;
            r_exc   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next != IDLE) begin
                r_cnt <= '0;
                r_exc <= w_next == DONE;
                r_mp  <= b;
                r_mc  <= {{W{1'b0}}, a};
                r_acc <= w_is_mul ? '0 : {{W{1'b0}}, a};
                if (w_next == DONE) begin
                    r_r <= '1;
                    r_s <= a;
                end
            end else if (r_state == MUL) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
                r_acc <= w_mul_acc;
                r_mc  <= r_mc << 1;
                r_mp  <= r_mp >> 1;
                if (w_next == DONE)
                    {r_s, r_r} <= w_mul_acc;
            end else if (r_state == DIV) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
                r_acc <= {w_rem, w_quo};
                if (w_next == DONE) begin
                    r_r <= w_quo;
                    r_s <= w_rem;
                end
            end
        end
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multicycle multiply/divide sequencer in the execute stage, alongside the single-cycle ALU. It accepts a MUL/DIV request from the execute buffer and runs an iterative 16-step shift-add multiply or restoring divide. While busy it stalls the pipeline. It returns a 32-bit result split as r (to the written register) and s (to R0), matching the ALU r/s convention.

Parameters:
REG_DATA_WIDTH, 16, operand/result half width
ALU_CONTROL_WIDTH, 4, width of alu_control
MUL_CODE, 4'b1000, alu_control value selecting unsigned multiply
DIV_CODE, 4'b1001, alu_control value selecting unsigned divide
CNT_WIDTH, 5, iteration counter width (must hold REG_DATA_WIDTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  request valid (execute-stage op issue)
alu_control  in  ALU_CONTROL_WIDTH  operation select
a  in  REG_DATA_WIDTH  multiplicand / dividend
b  in  REG_DATA_WIDTH  multiplier / divisor
flush  in  1  abort current operation
stall  out  1  freeze IF/ID/EX buffers and PC
busy  out  1  sequencer not in IDLE
done  out  1  one-cycle result-valid pulse
r  out  REG_DATA_WIDTH  product low half / quotient
s  out  REG_DATA_WIDTH  product high half / remainder
exc_div  out  1  divide-by-zero exception, valid with done

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst overrides all other inputs, including mid-operation: the next state is IDLE and stall, busy, done, exc_div, r, s and the counter all return to 0.
- States: IDLE, MUL, DIV, DONE. State is registered; stall and busy are combinational from state and inputs.
- Accept: in IDLE, start=1 with alu_control==MUL_CODE -> MUL; with DIV_CODE and b!=0 -> DIV; with DIV_CODE and b==0 -> DONE. Operands are latched on the accepting edge and the counter is cleared.
- start with any other alu_control: ignored, no stall.
- start while not IDLE: ignored. The pipeline is stalled, so the request is re-presented later.
- Cycle numbering: cycle 0 is the cycle start is sampled. MUL/DIV perform one iteration at the end of each of cycles 1..16. DONE occupies cycle 17, then the block returns to IDLE in cycle 18.
- MUL: 32-bit accumulator {hi,lo}, shift-add on the multiplier LSB each iteration. Unsigned result: {s,r} = a*b, width 32, no overflow possible.
- DIV: restoring division, unsigned. r = a/b, s = a%b.
- Divide by zero: DONE in cycle 1 with exc_div=1, r=16'hFFFF, s=a.
- stall = 1 in cycle 0 of an accepted MUL/DIV (combinational on start) and in all MUL/DIV cycles. stall = 0 in DONE, so the pipeline advances exactly as done writes back.
- done = 1 only in DONE, for exactly one cycle. exc_div is valid only with done and is 0 otherwise.
- r and s are registered and hold their last result until the next completion or reset.
- busy = (state != IDLE).
- flush=1 in any state except IDLE -> IDLE next cycle. No done pulse, and r/s are unchanged.
- flush and start both high in IDLE: flush wins and no request is accepted.
- rst and flush both high: rst wins; the result is identical, but r/s also clear.

Optional Feature:
MULDIV_EARLY_OUT_EN.
- Defined: in MUL, if the shifted remaining multiplier is zero after an iteration, the next state is DONE. The accumulator is shifted into its final alignment in that transition, so the result is unchanged and latency becomes (index of highest set bit of b)+2 cycles. b==0 -> DONE in cycle 2.
- Undefined: MUL always takes 16 iterations. DIV is unaffected in both cases.

Test Plan:
- MUL a=3, b=5 (macro off) -> stall cycles 0-16; done cycle 17; r=16'h000F, s=16'h0000, exc_div=0.
- MUL a=16'hFFFF, b=16'hFFFF -> done cycle 17; r=16'h0001, s=16'hFFFE.
- DIV a=100, b=7 -> done cycle 17; r=14, s=2. Back-to-back DIV a=16'h8000, b=16'h0003 issued in cycle 18 -> done cycle 35; r=16'h2AAA, s=2.
- DIV a=16'h1234, b=0 -> done cycle 1; exc_div=1, r=16'hFFFF, s=16'h1234; stall only in cycle 0.
- MUL a=3, b=5 with rst=1 in cycle 8 -> IDLE in cycle 9; all outputs 0; no done. Repeat with flush instead -> no done, r/s keep prior values.
- MULDIV_EARLY_OUT_EN defined, MUL a=3, b=5 -> done cycle 4, r=15, s=0. MUL a=7, b=0 -> done cycle 2, r=0, s=0.
